// File: rtl/pipeline_stall_ctrl_pkg.sv
// pipeline_stall_ctrl_pkg: shared state encodings and stall lengths for the hazard/stall controller.
package pipeline_stall_ctrl_pkg;
   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      DATA_STALL = 2'd1,
      BR_WAIT    = 2'd2
   } state_e;
   localparam int EX_STALL  = 2;
   localparam int MEM_STALL = 1;
   localparam int BR_STALL  = 2;
   localparam int CNT_W     = 2;
endpackage

// File: rtl/pipeline_stall_ctrl_dff.sv
// dff: register primitive with synchronous reset to a parameterised value.
module dff #(
   parameter int           W   = 1,
   parameter logic [W-1:0] RST = '0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   always_ff @(posedge clk) q <= reset ? RST : d;
endmodule

// File: rtl/pipeline_stall_ctrl_reg_match.sv
// reg_match: source register equals a nonzero destination register.
module reg_match (
   input  logic [4:0] src,
   input  logic [4:0] dst,
   output logic       match
);
   assign match = (src == dst) && (dst != 5'd0);
endmodule

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: detects EX/MEM load-use hazards and branches in ID and sequences
// the IF/ID stall and EX bubble outputs, counting stalled cycles.
module pipeline_stall_ctrl
   import pipeline_stall_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        id_valid,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        id_uses_rs,
   input  logic        id_uses_rt,
   input  logic        id_branch,
   input  logic        ex_regwr,
   input  logic [4:0]  ex_rw,
   input  logic        mem_regwr,
   input  logic [4:0]  mem_rw,
   output logic        if_stall,
   output logic        id_stall,
   output logic        ex_bubble,
   output logic [1:0]  state,
   output logic [15:0] stall_cycles
);
   logic [1:0]       state_q, state_d, cur;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [15:0]      sc_q, sc_d;
   logic             m_ex_rs, m_ex_rt, m_mem_rs, m_mem_rt, hz_ex, hz_mem, busy;

   reg_match u_ex_rs  (.src(id_rs), .dst(ex_rw),  .match(m_ex_rs));
   reg_match u_ex_rt  (.src(id_rt), .dst(ex_rw),  .match(m_ex_rt));
   reg_match u_mem_rs (.src(id_rs), .dst(mem_rw), .match(m_mem_rs));
   reg_match u_mem_rt (.src(id_rt), .dst(mem_rw), .match(m_mem_rt));

   dff #(.W(2))     u_state (.clk(clk), .reset(reset), .d(state_d), .q(state_q));
   dff #(.W(CNT_W)) u_cnt   (.clk(clk), .reset(reset), .d(cnt_d),   .q(cnt_q));
   dff #(.W(16))    u_sc    (.clk(clk), .reset(reset), .d(sc_d),    .q(sc_q));

   always_comb begin
      // the reset cycle behaves as IDLE even if a stall was in progress
      cur       = reset ? IDLE : state_q;
      hz_ex     = id_valid & ex_regwr & ((id_uses_rs & m_ex_rs) | (id_uses_rt & m_ex_rt));
      hz_mem    = id_valid & mem_regwr & ((id_uses_rs & m_mem_rs) | (id_uses_rt & m_mem_rt));
      busy      = cnt_q != '0;
      state_d   = IDLE;
      cnt_d     = '0;
      if_stall  = 1'b0;
      id_stall  = 1'b0;
      ex_bubble = 1'b0;
      case (cur)
         IDLE: begin
            if (hz_ex | hz_mem) begin
               {if_stall, id_stall, ex_bubble} = 3'b111;
               state_d = DATA_STALL;
               cnt_d   = hz_ex ? CNT_W'(EX_STALL - 1) : CNT_W'(MEM_STALL - 1);
            end else if (id_valid & id_branch) begin
               if_stall = 1'b1;
               state_d  = BR_WAIT;
               cnt_d    = CNT_W'(BR_STALL - 2);
            end
         end
         DATA_STALL: begin
            {if_stall, id_stall, ex_bubble} = {3{busy}};
            state_d = busy ? DATA_STALL : IDLE;
            cnt_d   = busy ? cnt_q - 1'b1 : '0;
         end
         BR_WAIT: begin
            if_stall = 1'b1;
            state_d  = busy ? BR_WAIT : IDLE;
            cnt_d    = busy ? cnt_q - 1'b1 : '0;
         end
         default: ;
      endcase
      sc_d = sc_q + 16'(if_stall & (sc_q != 16'hFFFF));
   end

   assign state        = state_q;
   assign stall_cycles = sc_q;
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb_pipeline_stall_ctrl: table-driven IDLE decode checks plus directed multi-cycle stall sequences.
module tb_pipeline_stall_ctrl;
   logic        clk = 1'b0;
   logic        reset;
   logic        id_valid, id_uses_rs, id_uses_rt, id_branch, ex_regwr, mem_regwr;
   logic [4:0]  id_rs, id_rt, ex_rw, mem_rw;
   logic        if_stall, id_stall, ex_bubble;
   logic [1:0]  state;
   logic [15:0] stall_cycles;
   int          n_cmp = 0;
   int          n_err = 0;

   typedef struct {
      logic       v;
      logic [4:0] rs, rt;
      logic       urs, urt, br, exw;
      logic [4:0] exrw;
      logic       memw;
      logic [4:0] memrw;
      logic [2:0] exp;
   } vec_t;
   vec_t vec[12];

   pipeline_stall_ctrl dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_branch(id_branch),
      .ex_regwr(ex_regwr), .ex_rw(ex_rw), .mem_regwr(mem_regwr), .mem_rw(mem_rw),
      .if_stall(if_stall), .id_stall(id_stall), .ex_bubble(ex_bubble),
      .state(state), .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clr;
      {id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_branch, ex_regwr, ex_rw, mem_regwr, mem_rw} = '0;
   endtask

   task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", n, act, exp);
      end
   endtask

   task automatic chk_o(input string n, input logic [2:0] exp, input logic [1:0] st);
      chk({n, "_out"}, {13'd0, if_stall, id_stall, ex_bubble}, {13'd0, exp});
      chk({n, "_st"}, {14'd0, state}, {14'd0, st});
   endtask

   initial begin
      vec[0]  = '{1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 3'b000};
      vec[1]  = '{1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 5'd0, 3'b111};
      vec[2]  = '{1'b1, 5'd1, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 5'd0, 3'b111};
      vec[3]  = '{1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd3, 3'b111};
      vec[4]  = '{1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 1'b1, 5'd0, 3'b000};
      vec[5]  = '{1'b1, 5'd5, 5'd2, 1'b0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 5'd0, 3'b000};
      vec[6]  = '{1'b1, 5'd6, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd6, 1'b0, 5'd6, 3'b000};
      vec[7]  = '{1'b1, 5'd4, 5'd8, 1'b1, 1'b1, 1'b1, 1'b1, 5'd2, 1'b1, 5'd3, 3'b100};
      vec[8]  = '{1'b1, 5'd4, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 5'd8, 3'b111};
      vec[9]  = '{1'b0, 5'd4, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 3'b000};
      vec[10] = '{1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 5'd7, 3'b111};
      vec[11] = '{1'b1, 5'd7, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 1'b1, 5'd7, 3'b000};
      reset = 1'b1;
      clr();
      tick();
      tick();
      // reset holds the FSM in IDLE, so each vector sees only the IDLE decode
      for (int i = 0; i < 12; i++) begin
         {id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt} = {vec[i].v, vec[i].rs, vec[i].rt, vec[i].urs, vec[i].urt};
         {id_branch, ex_regwr, ex_rw, mem_regwr, mem_rw} = {vec[i].br, vec[i].exw, vec[i].exrw, vec[i].memw, vec[i].memrw};
         #1;
         chk($sformatf("vec%0d", i), {13'd0, if_stall, id_stall, ex_bubble}, {13'd0, vec[i].exp});
      end
      clr();
      tick();
      reset = 1'b0;
      #1;
      chk_o("rst", 3'b000, 2'd0);
      chk("rst_sc", stall_cycles, 16'd0);
      id_valid = 1; id_rs = 5; id_uses_rs = 1; ex_regwr = 1; ex_rw = 5;
      #1; chk_o("ex_c0", 3'b111, 2'd0);
      tick(); chk_o("ex_c1", 3'b111, 2'd1);
      tick(); chk_o("ex_c2", 3'b000, 2'd1); clr();
      tick(); chk_o("ex_c3", 3'b000, 2'd0); chk("ex_sc", stall_cycles, 16'd2);
      id_valid = 1; id_rt = 7; id_uses_rt = 1; mem_regwr = 1; mem_rw = 7;
      #1; chk_o("mem_c0", 3'b111, 2'd0);
      tick(); chk_o("mem_c1", 3'b000, 2'd1); clr();
      tick(); chk_o("mem_c2", 3'b000, 2'd0); chk("mem_sc", stall_cycles, 16'd3);
      id_valid = 1; id_branch = 1;
      #1; chk_o("br_c0", 3'b100, 2'd0);
      tick(); chk_o("br_c1", 3'b100, 2'd2); clr();
      tick(); chk_o("br_c2", 3'b000, 2'd0); chk("br_sc", stall_cycles, 16'd5);
      id_valid = 1; id_branch = 1; id_rs = 5; id_uses_rs = 1; ex_regwr = 1; ex_rw = 5;
      #1; chk_o("bx_c0", 3'b111, 2'd0);
      tick(); chk_o("bx_c1", 3'b111, 2'd1);
      tick(); chk_o("bx_c2", 3'b000, 2'd1); ex_regwr = 0;
      tick(); chk_o("bx_c3", 3'b100, 2'd0);
      tick(); chk_o("bx_c4", 3'b100, 2'd2); clr();
      tick(); chk_o("bx_c5", 3'b000, 2'd0); chk("bx_sc", stall_cycles, 16'd9);
      id_valid = 1; id_rs = 5; id_uses_rs = 1; ex_regwr = 1; ex_rw = 5;
      tick(); chk_o("rm_c1", 3'b111, 2'd1);
      reset = 1'b1;
      #1; chk_o("rm_rst", 3'b111, 2'd1);
      tick(); reset = 1'b0; clr();
      #1; chk_o("rm_after", 3'b000, 2'd0); chk("rm_sc", stall_cycles, 16'd0);
      // a held branch stalls every cycle, walking the counter up to saturation
      id_valid = 1; id_branch = 1;
      for (int i = 0; i < 65534; i++) tick();
      chk("sat_fffe", stall_cycles, 16'hFFFE);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("sat_ffff_%0d", i), stall_cycles, 16'hFFFF);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/pipeline_stall_ctrl.md
PIPELINE_STALL_CTRL -- requirements
Module: pipeline_stall_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high; sampled on rising clk edge.
REQ-003 SHALL have ports: id_valid  in  1  ID stage holds a real instruction; id_rs, id_rt  in  5 each  ID source regs; id_uses_rs, id_uses_rt  in  1 each  operand actually read.
REQ-004 SHALL have ports: id_branch  in  1  ID holds beq/bne/bgtz.
REQ-005 SHALL have ports: ex_regwr, mem_regwr  in  1 each  stage will write reg file; ex_rw, mem_rw  in  5 each  destination reg.
REQ-006 SHALL have ports: if_stall  out  1  hold PC and IF/ID; id_stall  out  1  hold ID/EX inputs; ex_bubble  out  1  inject NOP into EX.
REQ-007 SHALL have ports: state  out  2  current FSM state; stall_cycles  out  16  saturating count of cycles with if_stall high.

Function
REQ-008 SHALL define hazard_ex = id_valid & ex_regwr & (ex_rw != 0) & ((id_uses_rs & id_rs == ex_rw) | (id_uses_rt & id_rt == ex_rw)).
REQ-009 SHALL define hazard_mem identically against mem_regwr/mem_rw; Wr-stage matches never stall (reg file write-before-read).
REQ-010 SHALL implement FSM states IDLE=0, DATA_STALL=1, BR_WAIT=2; encoding 3 unused, recovers to IDLE next cycle.
REQ-011 In IDLE with hazard_ex: SHALL assert if_stall, id_stall, ex_bubble this cycle, load cnt=1, go DATA_STALL (2 stall cycles total).
REQ-012 In IDLE with hazard_mem and not hazard_ex: SHALL assert all three stall outputs this cycle, stay IDLE path via DATA_STALL with cnt=0 (1 stall cycle total: exit next cycle without stalling).
REQ-013 In DATA_STALL: SHALL assert all three stall outputs while cnt!=0, decrement cnt; when cnt==0 deassert outputs and return to IDLE same cycle.
REQ-014 In IDLE with id_valid & id_branch and no hazard: SHALL assert if_stall only (id_stall=0, ex_bubble=0) this cycle, go BR_WAIT.
REQ-015 In BR_WAIT: SHALL assert if_stall for exactly one cycle, then return to IDLE (branch resolves in EX).
REQ-016 Data hazard SHALL take priority over branch; a stalled branch is re-evaluated in IDLE after DATA_STALL completes.
REQ-017 Stall outputs in IDLE SHALL be combinational from inputs (same-cycle); in DATA_STALL/BR_WAIT SHALL depend only on state/cnt, ignoring ID/EX/Mem inputs.
REQ-018 stall_cycles SHALL increment by 1 each cycle if_stall=1, saturating at 16'hFFFF.
REQ-019 id_valid=0 SHALL suppress both hazard and branch detection.

Reset
REQ-020 On reset SHALL set state=IDLE, cnt=0, stall_cycles=0; reset SHALL override any in-progress stall in the same edge.
REQ-021 During the reset cycle outputs SHALL follow IDLE rules; after reset release first cycle SHALL start from IDLE.

Structure
REQ-022 State encodings and stall lengths (EX=2, MEM=1, BR=2) SHALL be constants in the shared pipeline package.
REQ-023 Register comparison SHALL be one sub-module reg_match (5-bit equality plus nonzero-destination qualify), instantiated four times.
REQ-024 State and counters SHALL use the codebase dff primitive with synchronous reset gating.

Verification
REQ-025 EX hazard: id_rs=5, uses_rs=1, ex_rw=5, ex_regwr=1 -> if_stall/id_stall/ex_bubble high 2 cycles, then low; state 0->1->0.
REQ-026 MEM hazard: id_rt=7, uses_rt=1, mem_rw=7 -> stall outputs high exactly 1 cycle.
REQ-027 Zero register: id_rs=0, ex_rw=0, ex_regwr=1 -> no stall; uses_rs=0 with matching reg -> no stall.
REQ-028 Branch: id_branch=1, no hazard -> if_stall high 2 cycles, id_stall/ex_bubble stay 0, stall_cycles +2.
REQ-029 Branch with EX hazard -> 2 data-stall cycles, then 2 branch-stall cycles; stall_cycles +4.
REQ-030 Reset asserted mid-DATA_STALL -> next cycle state=0, stall_cycles=0; preload stall_cycles=16'hFFFE, stall 3 cycles -> holds 16'hFFFF.
